// File: rtl/ysyx_22041412_fetch_buf_if.sv
// Memory read port between the fetch buffer (master) and the memory arbiter (slave).
interface ysyx_22041412_fetch_buf_if #(
  parameter int AW = 64,
  parameter int DW = 32
) ();
  logic          valid_o;
  logic          ready_i;
  logic [7:0]    r_size_o;
  logic [AW-1:0] r_addr_o;
  logic [DW-1:0] r_data_i;

  modport master (output valid_o, r_size_o, r_addr_o, input ready_i, r_data_i);
  modport slave  (input valid_o, r_size_o, r_addr_o, output ready_i, r_data_i);
endinterface

// File: rtl/ysyx_22041412_fetch_buf.sv
// Instruction-fetch front end: single-outstanding sequential reads into a DEPTH-entry
// PC-tagged FIFO; redirect flushes the queue and cancels the in-flight fetch.
//
// state | meaning
// IDLE  | no request outstanding (after reset or queue full)
// REQ   | request outstanding, returned data is queued
// DROP  | request outstanding, returned data is discarded (redirect arrived mid-request)
module ysyx_22041412_fetch_buf #(
  parameter int            AW       = 64,
  parameter int            DW       = 32,
  parameter int            DEPTH    = 4,
  parameter logic [AW-1:0] RESET_PC = AW'(64'h8000_0000),
  parameter logic [7:0]    R_SIZE   = 8'h03
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          redirect_i,
  input  logic [AW-1:0] redirect_pc_i,
  input  logic          stall_i,
  output logic          inst_valid_o,
  output logic [DW-1:0] inst_o,
  output logic [AW-1:0] inst_pc_o,
  ysyx_22041412_fetch_buf_if.master mem
);
  localparam int            PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int            CW      = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [AW-1:0] INC     = AW'(DW / 8);

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  state_t        state;
  logic          run;
  logic          valid;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [AW-1:0] fetch_pc;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] data_q [DEPTH];
  logic [AW-1:0] pc_q   [DEPTH];
  logic          hs;
  logic          push;
  logic          pop;
  logic          room;

  assign hs   = valid & mem.ready_i;
  assign push = (state == REQ) & hs & ~redirect_i;
  assign pop  = (count != '0) & ~stall_i & ~redirect_i;
  assign room = count_nxt < DEPTH_C;

  always_comb begin
    count_nxt = count;
    if (redirect_i)
      count_nxt = '0;
    else if (push & ~pop)
      count_nxt = count + 1'b1;
    else if (pop & ~push)
      count_nxt = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      run      <= 1'b0;
      valid    <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fetch_pc <= RESET_PC;
      r_addr   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else begin
      // run delays the first request by one cycle after reset release
      run   <= 1'b1;
      count <= count_nxt;

      if (redirect_i) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) begin
          data_q[wr_ptr] <= mem.r_data_i;
          pc_q[wr_ptr]   <= fetch_pc;
          wr_ptr         <= wr_ptr + 1'b1;
        end
        if (pop)
          rd_ptr <= rd_ptr + 1'b1;
      end

      if (redirect_i)
        fetch_pc <= redirect_pc_i;
      else if (push)
        fetch_pc <= fetch_pc + INC;

      case (state)
        IDLE: begin
          if (run & room) begin
            state  <= REQ;
            valid  <= 1'b1;
            r_addr <= redirect_i ? redirect_pc_i : fetch_pc;
          end
        end
        REQ, DROP: begin
          if (hs) begin
            if (redirect_i) begin
              state  <= REQ;
              r_addr <= redirect_pc_i;
            end else if (room) begin
              state  <= REQ;
              r_addr <= (state == REQ) ? fetch_pc + INC : fetch_pc;
            end else begin
              state <= IDLE;
              valid <= 1'b0;
            end
          end else if (redirect_i) begin
            // address must stay stable until the outstanding request completes
            state <= DROP;
          end
        end
        default: begin
          state <= IDLE;
          valid <= 1'b0;
        end
      endcase
    end
  end

  assign inst_valid_o = (count != '0);
  assign inst_o       = data_q[rd_ptr];
  assign inst_pc_o    = pc_q[rd_ptr];
  assign mem.valid_o  = valid;
  assign mem.r_addr_o = r_addr;
  assign mem.r_size_o = R_SIZE;
endmodule

// File: tb/tb_ysyx_22041412_fetch_buf.sv
// Directed self-checking bench for the fetch buffer; memory returns {16'hA5A5, addr[15:0]}.
module tb_ysyx_22041412_fetch_buf;
  logic        clk;
  logic        rst_n;
  logic        redirect_i;
  logic [63:0] redirect_pc_i;
  logic        stall_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [63:0] inst_pc_o;
  logic        data_ovr;
  int          errors;
  int          checks;

  ysyx_22041412_fetch_buf_if #(.AW(64), .DW(32)) mif ();

  assign mif.r_data_i = data_ovr ? 32'hDEAD_BEEF : {16'hA5A5, mif.r_addr_o[15:0]};

  ysyx_22041412_fetch_buf dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .stall_i      (stall_i),
    .inst_valid_o (inst_valid_o),
    .inst_o       (inst_o),
    .inst_pc_o    (inst_pc_o),
    .mem          (mif.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++; if (mif.valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", mif.valid_o); end
    checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL rst_inst_valid: got %b expected 0", inst_valid_o); end
    checks++; if (mif.r_addr_o !== 64'h0) begin errors++; $display("FAIL rst_addr: got %h expected 0", mif.r_addr_o); end
    checks++; if (inst_o !== 32'h0) begin errors++; $display("FAIL rst_inst: got %h expected 0", inst_o); end
    checks++; if (mif.r_size_o !== 8'h03) begin errors++; $display("FAIL rst_size: got %h expected 03", mif.r_size_o); end
    rst_n = 1'b1;
    tick();
    checks++; if (mif.valid_o !== 1'b0) begin errors++; $display("FAIL rel_1st_valid: got %b expected 0", mif.valid_o); end
    tick();
    checks++; if (mif.valid_o !== 1'b1) begin errors++; $display("FAIL rel_2nd_valid: got %b expected 1", mif.valid_o); end
    checks++; if (mif.r_addr_o !== 64'h8000_0000) begin errors++; $display("FAIL rel_addr: got %h expected 80000000", mif.r_addr_o); end
  endtask

  task automatic test_stream();
    mif.ready_i = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++; if (mif.r_addr_o !== 64'h8000_0000 + 64'(4 * i)) begin errors++; $display("FAIL stream_addr%0d: got %h expected %h", i, mif.r_addr_o, 64'h8000_0000 + 64'(4 * i)); end
    end
    tick();
    checks++; if (mif.valid_o !== 1'b0) begin errors++; $display("FAIL stream_full_valid: got %b expected 0", mif.valid_o); end
    checks++; if (inst_pc_o !== 64'h8000_0000) begin errors++; $display("FAIL stream_head_pc: got %h expected 80000000", inst_pc_o); end
    checks++; if (inst_o !== 32'hA5A5_0000) begin errors++; $display("FAIL stream_head_inst: got %h expected a5a50000", inst_o); end
    repeat (2) tick();
    checks++; if (mif.valid_o !== 1'b0) begin errors++; $display("FAIL stream_hold_valid: got %b expected 0", mif.valid_o); end
    mif.ready_i = 1'b0;
    stall_i = 1'b0;
    tick();
    checks++; if (mif.valid_o !== 1'b1 || mif.r_addr_o !== 64'h8000_0010) begin errors++; $display("FAIL stream_resume: got valid %b addr %h expected 1 80000010", mif.valid_o, mif.r_addr_o); end
    checks++; if (inst_pc_o !== 64'h8000_0004) begin errors++; $display("FAIL stream_pop1: got %h expected 80000004", inst_pc_o); end
    tick();
    checks++; if (inst_pc_o !== 64'h8000_0008) begin errors++; $display("FAIL stream_pop2: got %h expected 80000008", inst_pc_o); end
    tick();
    checks++; if (inst_pc_o !== 64'h8000_000C || inst_o !== 32'hA5A5_000C) begin errors++; $display("FAIL stream_pop3: got %h %h expected 8000000c a5a5000c", inst_pc_o, inst_o); end
    tick();
    checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL stream_empty: got %b expected 0", inst_valid_o); end
  endtask

  task automatic test_redirect_mid_req();
    redirect_i = 1'b1;
    redirect_pc_i = 64'h8000_0800;
    tick();
    checks++; if (mif.valid_o !== 1'b1 || mif.r_addr_o !== 64'h8000_0010) begin errors++; $display("FAIL drop_hold: got valid %b addr %h expected 1 80000010", mif.valid_o, mif.r_addr_o); end
    redirect_pc_i = 64'h8000_1000;
    tick();
    redirect_i = 1'b0;
    checks++; if (mif.r_addr_o !== 64'h8000_0010) begin errors++; $display("FAIL drop_hold2: got %h expected 80000010", mif.r_addr_o); end
    mif.ready_i = 1'b1;
    data_ovr = 1'b1;
    tick();
    mif.ready_i = 1'b0;
    data_ovr = 1'b0;
    checks++; if (mif.r_addr_o !== 64'h8000_1000 || mif.valid_o !== 1'b1) begin errors++; $display("FAIL drop_next_addr: got valid %b addr %h expected 1 80001000", mif.valid_o, mif.r_addr_o); end
    checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL drop_discard: got %b expected 0", inst_valid_o); end
    tick();
    checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL drop_discard2: got %b expected 0", inst_valid_o); end
  endtask

  task automatic test_redirect_with_hs();
    mif.ready_i = 1'b1;
    redirect_i = 1'b1;
    redirect_pc_i = 64'h8000_2000;
    tick();
    mif.ready_i = 1'b0;
    redirect_i = 1'b0;
    checks++; if (mif.r_addr_o !== 64'h8000_2000 || mif.valid_o !== 1'b1) begin errors++; $display("FAIL rdhs_addr: got valid %b addr %h expected 1 80002000", mif.valid_o, mif.r_addr_o); end
    tick();
    checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL rdhs_discard: got %b expected 0", inst_valid_o); end
  endtask

  task automatic test_push_pop_wrap();
    stall_i = 1'b1;
    mif.ready_i = 1'b1;
    repeat (3) tick();
    mif.ready_i = 1'b0;
    checks++; if (inst_pc_o !== 64'h8000_2000 || inst_o !== 32'hA5A5_2000) begin errors++; $display("FAIL wrap_head0: got %h %h expected 80002000 a5a52000", inst_pc_o, inst_o); end
    checks++; if (mif.r_addr_o !== 64'h8000_200C) begin errors++; $display("FAIL wrap_addr0: got %h expected 8000200c", mif.r_addr_o); end
    stall_i = 1'b0;
    mif.ready_i = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++; if (inst_pc_o !== 64'h8000_2000 + 64'(4 * i)) begin errors++; $display("FAIL wrap_head%0d: got %h expected %h", i, inst_pc_o, 64'h8000_2000 + 64'(4 * i)); end
      checks++; if (mif.valid_o !== 1'b1 || mif.r_addr_o !== 64'h8000_200C + 64'(4 * i)) begin errors++; $display("FAIL wrap_addr%0d: got %h expected %h", i, mif.r_addr_o, 64'h8000_200C + 64'(4 * i)); end
    end
    mif.ready_i = 1'b0;
    tick();
    checks++; if (inst_pc_o !== 64'h8000_2010 || inst_valid_o !== 1'b1) begin errors++; $display("FAIL wrap_drain1: got %h expected 80002010", inst_pc_o); end
    tick();
    checks++; if (inst_pc_o !== 64'h8000_2014 || inst_o !== 32'hA5A5_2014) begin errors++; $display("FAIL wrap_drain2: got %h %h expected 80002014 a5a52014", inst_pc_o, inst_o); end
    tick();
    checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL wrap_count: got %b expected 0", inst_valid_o); end
  endtask

  task automatic test_reset_mid_req();
    checks++; if (mif.valid_o !== 1'b1 || mif.r_addr_o !== 64'h8000_2018) begin errors++; $display("FAIL rstmid_pre: got valid %b addr %h expected 1 80002018", mif.valid_o, mif.r_addr_o); end
    mif.ready_i = 1'b1;
    rst_n = 1'b0;
    tick();
    checks++; if (mif.valid_o !== 1'b0 || inst_valid_o !== 1'b0 || mif.r_addr_o !== 64'h0) begin errors++; $display("FAIL rstmid_state: got valid %b iv %b addr %h expected 0 0 0", mif.valid_o, inst_valid_o, mif.r_addr_o); end
    rst_n = 1'b1;
    mif.ready_i = 1'b0;
    tick();
    checks++; if (mif.valid_o !== 1'b0) begin errors++; $display("FAIL rstmid_rel1: got %b expected 0", mif.valid_o); end
    tick();
    checks++; if (mif.valid_o !== 1'b1 || mif.r_addr_o !== 64'h8000_0000) begin errors++; $display("FAIL rstmid_restart: got valid %b addr %h expected 1 80000000", mif.valid_o, mif.r_addr_o); end
    checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL rstmid_empty: got %b expected 0", inst_valid_o); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    redirect_i = 1'b0;
    redirect_pc_i = 64'h0;
    stall_i = 1'b1;
    mif.ready_i = 1'b0;
    data_ovr = 1'b0;
    test_reset();
    test_stream();
    test_redirect_mid_req();
    test_redirect_with_hs();
    test_push_pop_wrap();
    test_reset_mid_req();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
